// File: rtl/i2s_rx_controller.sv
// i2s_rx_controller: I2S master receive controller.
// Generates sck_o/ws_o for the attached ADC/microphone, captures sd_i on sck
// rising edges into left/right sample registers (MSB first) and hands each
// completed stereo frame downstream over a valid/ready interface.
// Optional feature macro: I2S_OVERRUN_DETECT_EN adds a sticky overrun_o flag
// that records a frame dropped because the consumer was still stalling.

// Binary-to-one-hot decoder: onehot[i] is set when bin == i.
module bin_to_onehot #(
    parameter int IN_WIDTH  = 5,
    parameter int OUT_WIDTH = 32
) (
    input  logic [IN_WIDTH-1:0]  bin,
    output logic [OUT_WIDTH-1:0] onehot
);

    // Compare the binary input against every output position.
    always_comb begin
        // NOTE: every output bit is assigned on every pass, so no latch is inferred.
        onehot = '0;
        for (int i = 0; i < OUT_WIDTH; i++) begin
            onehot[i] = (bin == IN_WIDTH'(i));
        end
    end

endmodule

module i2s_rx_controller #(
    parameter int CLK_DIV       = 4,
    parameter int SLOT_WIDTH    = 32,
    parameter int SAMPLE_WIDTH  = 24,
    parameter int BIT_CNT_WIDTH = 5
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    en_i,
    input  logic                    sd_i,
    output logic                    sck_o,
    output logic                    ws_o,
    output logic [SAMPLE_WIDTH-1:0] left_o,
    output logic [SAMPLE_WIDTH-1:0] right_o,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic                    busy_o
`ifdef I2S_OVERRUN_DETECT_EN
    ,
    output logic                    overrun_o
`endif
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                   state;
    logic [DIV_W-1:0]         div_cnt;
    logic [BIT_CNT_WIDTH-1:0] bit_cnt;
    logic                     ch;
    logic [SAMPLE_WIDTH-1:0]  left_sh;
    logic [SAMPLE_WIDTH-1:0]  right_sh;
    logic                     frame_done;

    logic                     div_tc;
    logic                     sck_rise;
    logic                     sck_fall;
    logic                     bit_wrap;
    logic [BIT_CNT_WIDTH-1:0] bit_cnt_next;
    logic                     ch_next;
    logic                     ws_next;
    logic                     frame_last;
    logic [SAMPLE_WIDTH-1:0]  slot_onehot;
    logic [SAMPLE_WIDTH-1:0]  bit_we;

    // Bit counter position -> one-hot; positions at or beyond SAMPLE_WIDTH
    // have no output, so the padding bits of each slot are never written.
    bin_to_onehot #(
        .IN_WIDTH  (BIT_CNT_WIDTH),
        .OUT_WIDTH (SAMPLE_WIDTH)
    ) u_bit_dec (
        .bin    (bit_cnt),
        .onehot (slot_onehot)
    );

    // Divider terminal count, sck edge events and next-slot bookkeeping.
    always_comb begin
        div_tc       = (div_cnt == DIV_W'(CLK_DIV - 1));
        sck_rise     = div_tc && !sck_o;
        sck_fall     = div_tc && sck_o;
        bit_wrap     = (bit_cnt == BIT_CNT_WIDTH'(SLOT_WIDTH - 1));
        bit_cnt_next = bit_wrap ? '0 : bit_cnt + BIT_CNT_WIDTH'(1);
        ch_next      = ch ^ bit_wrap;
        // WS changes one sck ahead of the slot it announces.
        ws_next      = ch_next ^ (bit_cnt_next == BIT_CNT_WIDTH'(SLOT_WIDTH - 1));
        frame_last   = sck_rise && ch && (bit_cnt == BIT_CNT_WIDTH'(SAMPLE_WIDTH - 1));
    end

    // Sample bit j is written when bit_cnt == SAMPLE_WIDTH-1-j (MSB first).
    always_comb begin
        bit_we = '0;
        for (int j = 0; j < SAMPLE_WIDTH; j++) begin
            bit_we[j] = sck_rise && slot_onehot[SAMPLE_WIDTH-1-j];
        end
    end

    // Controller FSM with registered outputs: clocking, capture and handshake.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            ch         <= 1'b0;
            sck_o      <= 1'b0;
            ws_o       <= 1'b0;
            busy_o     <= 1'b0;
            // NOTE: the sample shift registers are plain flops, so they are reset like any other state.
            left_sh    <= '0;
            right_sh   <= '0;
            frame_done <= 1'b0;
            left_o     <= '0;
            right_o    <= '0;
            valid_o    <= 1'b0;
`ifdef I2S_OVERRUN_DETECT_EN
            overrun_o  <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments make every flop here see pre-edge values.
            frame_done <= 1'b0;

            // Output stage: load a completed frame unless a stalled one is held.
            if (frame_done && (!valid_o || ready_i)) begin
                left_o  <= left_sh;
                right_o <= right_sh;
                valid_o <= 1'b1;
            end else if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end
`ifdef I2S_OVERRUN_DETECT_EN
            if (frame_done && valid_o && !ready_i) begin
                overrun_o <= 1'b1;
            end
`endif

            case (state)
                IDLE: begin
                    div_cnt <= '0;
                    bit_cnt <= '0;
                    ch      <= 1'b0;
                    sck_o   <= 1'b0;
                    ws_o    <= 1'b0;
                    if (en_i) begin
                        state  <= RUN;
                        busy_o <= 1'b1;
`ifdef I2S_OVERRUN_DETECT_EN
                        overrun_o <= 1'b0;
`endif
                    end
                end

                RUN: begin
                    if (!en_i) begin
                        // Abort: drop the partial frame, keep the presented one.
                        state    <= IDLE;
                        busy_o   <= 1'b0;
                        div_cnt  <= '0;
                        bit_cnt  <= '0;
                        ch       <= 1'b0;
                        sck_o    <= 1'b0;
                        ws_o     <= 1'b0;
                        left_sh  <= '0;
                        right_sh <= '0;
                    end else begin
                        if (div_tc) begin
                            div_cnt <= '0;
                            sck_o   <= ~sck_o;
                        end else begin
                            div_cnt <= div_cnt + DIV_W'(1);
                        end

                        if (sck_fall) begin
                            bit_cnt <= bit_cnt_next;
                            ch      <= ch_next;
                            ws_o    <= ws_next;
                        end

                        for (int j = 0; j < SAMPLE_WIDTH; j++) begin
                            if (bit_we[j]) begin
                                if (ch) begin
                                    right_sh[j] <= sd_i;
                                end else begin
                                    left_sh[j] <= sd_i;
                                end
                            end
                        end

                        if (frame_last) begin
                            frame_done <= 1'b1;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
